// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: control-bundle bit layout, load-size encodings and the
// write-back source selection helper shared by the write-back stage files.
// The `CTRL_* / `LOAD_SIZE_* macros are the shared constants for the core;
// this file is compiled first so the macros are visible to all later files.
// Optional feature macro used by the stage: WB_LOAD_EXT_EN.
`ifndef WB_CONSTANTS_DEFINED
`define WB_CONSTANTS_DEFINED
`define CONTROL_SIGNALS_WIDTH 6
`define CTRL_MEM_TO_REG       0
`define CTRL_REG_WRITE        1
`define CTRL_JUMP             2
// Low bit of the 2-bit load-size field, occupying [`CTRL_LOAD_SIZE +: 2]
`define CTRL_LOAD_SIZE        3
`define CTRL_LOAD_UNSIGNED    5
`define LOAD_SIZE_WORD        2'b00
`define LOAD_SIZE_BYTE        2'b01
`define LOAD_SIZE_HALF        2'b10
`define LOAD_SIZE_RSVD        2'b11
`endif

package wb_stage_pkg;

   localparam int unsigned LOAD_SIZE_W = 2;

   // Write-back value source
   typedef enum logic [1:0] {
      SRC_ALU  = 2'b00,
      SRC_LOAD = 2'b01,
      SRC_PC   = 2'b10
   } wb_src_e;

   // Jump outranks memory-to-register; everything else is the ALU result.
   function automatic wb_src_e wb_select_src(input logic jump, input logic mem_to_reg);
      wb_src_e src;
      if (jump) begin
         src = SRC_PC;
      end else if (mem_to_reg) begin
         src = SRC_LOAD;
      end else begin
         src = SRC_ALU;
      end
      return src;
   endfunction

endpackage

// File: rtl/wb_stage_load_ext.sv
// wb_load_ext: narrows raw load data to byte/halfword/word and sign- or
// zero-extends it back to XLEN. The reserved size code behaves as word.
module wb_load_ext
   import wb_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]        data_i,
   input  logic [LOAD_SIZE_W-1:0] size_i,
   input  logic                   unsigned_i,
   output logic [XLEN-1:0]        data_o
);

   logic byte_fill_s;
   logic half_fill_s;

   // Fill bit is the loaded value's top bit for signed loads, zero otherwise
   always_comb begin
      byte_fill_s = unsigned_i ? 1'b0 : data_i[7];
      half_fill_s = unsigned_i ? 1'b0 : data_i[15];
   end

   // Size-dependent narrowing and extension
   always_comb begin
      data_o = data_i;
      case (size_i)
         `LOAD_SIZE_WORD: data_o = data_i;
         `LOAD_SIZE_BYTE: data_o = {{(XLEN-8){byte_fill_s}}, data_i[7:0]};
         `LOAD_SIZE_HALF: data_o = {{(XLEN-16){half_fill_s}}, data_i[15:0]};
         `LOAD_SIZE_RSVD: data_o = data_i;
         default:         data_o = data_i;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage. Selects the value written to the register
// file (combinationally), gates the write enable for x0, and keeps a
// registered copy of the last committed write for WB-to-ID bypassing.
// Build option: define WB_LOAD_EXT_EN to enable byte/halfword load
// extension through wb_load_ext; otherwise load data passes unchanged.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [XLEN-1:0]                   mem_wb_alu_result,
   input  logic [XLEN-1:0]                   mem_wb_mem_data,
   input  logic [XLEN-1:0]                   mem_wb_pc_plus4,
   input  logic [4:0]                        mem_wb_rd,
   input  logic [`CONTROL_SIGNALS_WIDTH-1:0] mem_wb_control_signals,
   output logic [XLEN-1:0]                   wb_data,
   output logic [4:0]                        wb_rd,
   output logic                              wb_reg_write,
   output logic                              wb_last_valid,
   output logic [4:0]                        wb_last_rd,
   output logic [XLEN-1:0]                   wb_last_data
);

   logic [XLEN-1:0] load_val_s;
   wb_src_e         src_s;

   logic            last_valid_d, last_valid_q;
   logic [4:0]      last_rd_d,    last_rd_q;
   logic [XLEN-1:0] last_data_d,  last_data_q;

`ifdef WB_LOAD_EXT_EN
   wb_load_ext #(
      .XLEN (XLEN)
   ) u_load_ext (
      .data_i     (mem_wb_mem_data),
      .size_i     (mem_wb_control_signals[`CTRL_LOAD_SIZE +: LOAD_SIZE_W]),
      .unsigned_i (mem_wb_control_signals[`CTRL_LOAD_UNSIGNED]),
      .data_o     (load_val_s)
   );
`else
   logic unused_load_ctrl_s;

   // Size/unsigned fields are don't-care when extension is compiled out
   always_comb begin
      unused_load_ctrl_s = ^{mem_wb_control_signals[`CTRL_LOAD_SIZE +: LOAD_SIZE_W],
                             mem_wb_control_signals[`CTRL_LOAD_UNSIGNED]};
      load_val_s         = mem_wb_mem_data;
   end
`endif

   // Source select; register-write enable plays no part in the choice
   always_comb begin
      src_s = wb_select_src(mem_wb_control_signals[`CTRL_JUMP],
                            mem_wb_control_signals[`CTRL_MEM_TO_REG]);
      case (src_s)
         SRC_PC:   wb_data = mem_wb_pc_plus4;
         SRC_LOAD: wb_data = load_val_s;
         SRC_ALU:  wb_data = mem_wb_alu_result;
         default:  wb_data = mem_wb_alu_result;
      endcase
   end

   // Destination passes through; writes to x0 are suppressed
   always_comb begin
      wb_rd        = mem_wb_rd;
      wb_reg_write = mem_wb_control_signals[`CTRL_REG_WRITE] && (mem_wb_rd != 5'd0);
   end

   // Bypass next state: capture a committed write, otherwise hold
   always_comb begin
      last_valid_d = last_valid_q;
      last_rd_d    = last_rd_q;
      last_data_d  = last_data_q;
      if (wb_reg_write) begin
         last_valid_d = 1'b1;
         last_rd_d    = mem_wb_rd;
         last_data_d  = wb_data;
      end else begin
         last_valid_d = last_valid_q;
         last_rd_d    = last_rd_q;
         last_data_d  = last_data_q;
      end
   end

   // Bypass register, cleared immediately by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_valid_q <= 1'b0;
         last_rd_q    <= 5'd0;
         last_data_q  <= {XLEN{1'b0}};
      end else begin
         last_valid_q <= last_valid_d;
         last_rd_q    <= last_rd_d;
         last_data_q  <= last_data_d;
      end
   end

   // Bypass outputs come straight from the register
   always_comb begin
      wb_last_valid = last_valid_q;
      wb_last_rd    = last_rd_q;
      wb_last_data  = last_data_q;
   end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage. A driver applies directed and
// random transactions on the falling edge and queues the expected response
// from a behavioural model; a monitor pops and compares shortly afterwards.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] alu_s = 32'd0;
   logic [31:0] mem_s = 32'd0;
   logic [31:0] pc_s  = 32'd0;
   logic [4:0]  rd_s  = 5'd0;
   logic [`CONTROL_SIGNALS_WIDTH-1:0] ctrl_s = '0;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic        wb_last_valid;
   logic [4:0]  wb_last_rd;
   logic [31:0] wb_last_data;

   int passed = 0;
   int total  = 0;

   typedef struct {
      string       tag;
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ldata;
   } exp_t;

   exp_t exp_q[$];

   // Reference bypass contents: what the register should hold right now
   logic        m_lv    = 1'b0;
   logic [4:0]  m_lrd   = 5'd0;
   logic [31:0] m_ldata = 32'd0;

   always #5 clk = ~clk;

   wb_stage #(.XLEN(32)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .mem_wb_alu_result      (alu_s),
      .mem_wb_mem_data        (mem_s),
      .mem_wb_pc_plus4        (pc_s),
      .mem_wb_rd              (rd_s),
      .mem_wb_control_signals (ctrl_s),
      .wb_data                (wb_data),
      .wb_rd                  (wb_rd),
      .wb_reg_write           (wb_reg_write),
      .wb_last_valid          (wb_last_valid),
      .wb_last_rd             (wb_last_rd),
      .wb_last_data           (wb_last_data)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   function automatic logic [`CONTROL_SIGNALS_WIDTH-1:0] mk_ctrl(
      input logic jump, input logic mtr, input logic rw,
      input logic [1:0] size, input logic uns);
      logic [`CONTROL_SIGNALS_WIDTH-1:0] c;
      c = '0;
      c[`CTRL_JUMP]          = jump;
      c[`CTRL_MEM_TO_REG]    = mtr;
      c[`CTRL_REG_WRITE]     = rw;
      c[`CTRL_LOAD_SIZE]     = size[0];
      c[`CTRL_LOAD_SIZE + 1] = size[1];
      c[`CTRL_LOAD_UNSIGNED] = uns;
      return c;
   endfunction

   // Loaded value from the load rules, using plain arithmetic
   function automatic logic [31:0] model_load(input logic [31:0] mem, input int size, input logic uns);
      int unsigned v;
      v = mem;
`ifdef WB_LOAD_EXT_EN
      if (size == 1) begin
         v = mem % 256;
         if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (size == 2) begin
         v = mem % 65536;
         if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      end
`endif
      return v;
   endfunction

   // Drive one transaction and queue the expected response.
   // use_exp forces the data expectation to a hand-derived constant.
   task automatic drive(input string tag, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] pc, input logic [4:0] rd,
                        input logic [`CONTROL_SIGNALS_WIDTH-1:0] ctrl,
                        input bit use_exp, input logic [31:0] exp_data);
      exp_t e;
      int size;
      @(negedge clk);
      alu_s = alu; mem_s = mem; pc_s = pc; rd_s = rd; ctrl_s = ctrl;
      size = {30'd0, ctrl[`CTRL_LOAD_SIZE + 1], ctrl[`CTRL_LOAD_SIZE]};
      e.tag = tag;
      if (ctrl[`CTRL_JUMP])            e.data = pc;
      else if (ctrl[`CTRL_MEM_TO_REG]) e.data = model_load(mem, size, ctrl[`CTRL_LOAD_UNSIGNED]);
      else                             e.data = alu;
      if (use_exp) e.data = exp_data;
      e.rd    = rd;
      e.we    = ctrl[`CTRL_REG_WRITE] && (rd != 5'd0);
      e.lv    = m_lv;
      e.lrd   = m_lrd;
      e.ldata = m_ldata;
      exp_q.push_back(e);
      if (e.we && !rst) begin
         m_lv = 1'b1; m_lrd = rd; m_ldata = e.data;
      end
   endtask

   // Monitor: compare the outstanding transaction once inputs have settled
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, ".data"}, wb_data, e.data);
            chk({e.tag, ".rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
            chk({e.tag, ".we"}, {31'd0, wb_reg_write}, {31'd0, e.we});
            chk({e.tag, ".last"}, {wb_last_valid, wb_last_rd, wb_last_data[25:0]},
                                  {e.lv, e.lrd, e.ldata[25:0]});
            chk({e.tag, ".ldata"}, wb_last_data, e.ldata);
         end
      end
   end

   initial begin
      logic [31:0] exp_035a, exp_035b, exp_035c;
      int waited;
`ifdef WB_LOAD_EXT_EN
      exp_035a = 32'hFFFF_FFF0; exp_035b = 32'h0000_00F0; exp_035c = 32'hFFFF_80F0;
`else
      exp_035a = 32'h0000_80F0; exp_035b = 32'h0000_80F0; exp_035c = 32'h0000_80F0;
`endif
      // Reset state
      #3;
      chk("reset.valid", {31'd0, wb_last_valid}, 32'd0);
      chk("reset.rd", {27'd0, wb_last_rd}, 32'd0);
      chk("reset.data", wb_last_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors
      drive("alu_path", 32'hDEAD_BEEF, 32'hCAFE_BABE, 32'd0, 5'd1, '0, 1'b1, 32'hDEAD_BEEF);
      drive("mem_word", 32'hDEAD_BEEF, 32'hCAFE_BABE, 32'd0, 5'd1,
            mk_ctrl(1'b0, 1'b1, 1'b0, `LOAD_SIZE_WORD, 1'b0), 1'b1, 32'hCAFE_BABE);
      drive("nowr_alu", 32'h1234_5678, 32'h8765_4321, 32'd0, 5'd7,
            mk_ctrl(1'b0, 1'b0, 1'b0, `LOAD_SIZE_WORD, 1'b0), 1'b1, 32'h1234_5678);
      drive("nowr_mem", 32'h1234_5678, 32'h8765_4321, 32'd0, 5'd7,
            mk_ctrl(1'b0, 1'b1, 1'b0, `LOAD_SIZE_WORD, 1'b0), 1'b1, 32'h8765_4321);
      drive("byte_s", 32'd0, 32'h0000_80F0, 32'd0, 5'd2,
            mk_ctrl(1'b0, 1'b1, 1'b0, `LOAD_SIZE_BYTE, 1'b0), 1'b1, exp_035a);
      drive("byte_u", 32'd0, 32'h0000_80F0, 32'd0, 5'd2,
            mk_ctrl(1'b0, 1'b1, 1'b0, `LOAD_SIZE_BYTE, 1'b1), 1'b1, exp_035b);
      drive("half_s", 32'd0, 32'h0000_80F0, 32'd0, 5'd2,
            mk_ctrl(1'b0, 1'b1, 1'b0, `LOAD_SIZE_HALF, 1'b0), 1'b1, exp_035c);
      drive("rsvd", 32'd0, 32'h0000_80F0, 32'd0, 5'd2,
            mk_ctrl(1'b0, 1'b1, 1'b0, `LOAD_SIZE_RSVD, 1'b0), 1'b1, 32'h0000_80F0);
      drive("jump", 32'h1111_1111, 32'h2222_2222, 32'h0000_0104, 5'd3,
            mk_ctrl(1'b1, 1'b1, 1'b1, `LOAD_SIZE_WORD, 1'b0), 1'b1, 32'h0000_0104);
      drive("x0", 32'h3333_3333, 32'd0, 32'd0, 5'd0,
            mk_ctrl(1'b0, 1'b0, 1'b1, `LOAD_SIZE_WORD, 1'b0), 1'b1, 32'h3333_3333);
      drive("bypass", 32'hA5A5_A5A5, 32'd0, 32'd0, 5'd5,
            mk_ctrl(1'b0, 1'b0, 1'b1, `LOAD_SIZE_WORD, 1'b0), 1'b1, 32'hA5A5_A5A5);
      drive("hold", 32'h5A5A_5A5A, 32'd0, 32'd0, 5'd6, '0, 1'b1, 32'h5A5A_5A5A);

      // Reset asserted between edges clears the bypass immediately
      #4;
      rst = 1'b1;
      #1;
      chk("midrst.valid", {31'd0, wb_last_valid}, 32'd0);
      chk("midrst.rd", {27'd0, wb_last_rd}, 32'd0);
      chk("midrst.data", wb_last_data, 32'd0);
      m_lv = 1'b0; m_lrd = 5'd0; m_ldata = 32'd0;
      // Combinational path keeps working under reset; no capture happens
      drive("in_rst", 32'hC0DE_0001, 32'd0, 32'd0, 5'd9,
            mk_ctrl(1'b0, 1'b0, 1'b1, `LOAD_SIZE_WORD, 1'b0), 1'b1, 32'hC0DE_0001);
      drive("in_rst2", 32'hC0DE_0002, 32'd0, 32'd0, 5'd10, '0, 1'b0, 32'd0);
      @(negedge clk);
      #3;
      rst = 1'b0;

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         logic [4:0] rd;
         rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
         drive("rand", $urandom, $urandom, $urandom, rd,
               `CONTROL_SIGNALS_WIDTH'($urandom), 1'b0, 32'd0);
      end

      // Drain the scoreboard within a bounded number of cycles
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      #3;
      chk("drain", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
